// File: rtl/etapa_decodificacion_if.sv
// Fetch -> decode -> execute signal bundle for the decode stage.
// The stage owns the slave side; the fetch/execute environment owns the master side.
interface etapa_decodificacion_if;
    logic [31:0] instr_in;
    logic        instr_valid_in;
    logic        done_in;
    logic        flush;
    logic        stall_in;
    logic        stall_out;
    logic        valid_out;
    logic [4:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] imm;
    logic [31:0] instr_out;
    logic        halt_out;

    modport master (
        output instr_in, instr_valid_in, done_in, flush, stall_in,
        input  stall_out, valid_out, opcode, rd, rs1, rs2, imm, instr_out, halt_out
    );

    modport slave (
        input  instr_in, instr_valid_in, done_in, flush, stall_in,
        output stall_out, valid_out, opcode, rd, rs1, rs2, imm, instr_out, halt_out
    );
endinterface

// File: rtl/etapa_decodificacion.sv
// Decode stage: registers the fetched word behind a one-entry skid buffer,
// slices it into fields, squashes on flush and latches a sticky halt.
module etapa_decodificacion #(
    parameter logic [4:0] HALT_OP    = 5'b01011,
    parameter bit         IMM_SIGNED = 1'b1
) (
    input logic                    clk,
    input logic                    rst_n,
    etapa_decodificacion_if.slave  bus
);

    logic [31:0] word_q, word_d;
    logic [31:0] skid_q, skid_d;
    logic        valid_q, valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic        stall_q, stall_d;
    logic        halt_q, halt_d;
    logic        accept;

    always_comb begin
        accept       = bus.instr_valid_in && !stall_q && !bus.done_in && !halt_q && !bus.flush;
        word_d       = word_q;
        skid_d       = skid_q;
        valid_d      = valid_q;
        skid_valid_d = skid_valid_q;
        halt_d       = halt_q | (bus.done_in && !stall_q && !bus.flush);

        if (bus.flush) begin
            // Squash both entries; the field registers may keep stale data.
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!bus.stall_in) begin
            if (skid_valid_q) begin
                word_d       = skid_q;
                valid_d      = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                valid_d = accept;
                if (accept) word_d = bus.instr_in;
            end
        end else if (accept) begin
            skid_d       = bus.instr_in;
            skid_valid_d = 1'b1;
        end

        stall_d = bus.stall_in | skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q       <= '0;
            skid_q       <= '0;
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            stall_q      <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            word_q       <= word_d;
            skid_q       <= skid_d;
            valid_q      <= valid_d;
            skid_valid_q <= skid_valid_d;
            stall_q      <= stall_d;
            halt_q       <= halt_d;
        end
    end

    assign bus.valid_out = valid_q;
    assign bus.stall_out = stall_q;
    assign bus.halt_out  = halt_q;
    assign bus.instr_out = word_q;
    assign bus.opcode    = word_q[31:27];
    assign bus.rd        = word_q[26:23];
    assign bus.rs1       = word_q[22:19];
    assign bus.rs2       = word_q[18:15];

    generate
        if (IMM_SIGNED) begin : g_imm_sext
            assign bus.imm = {{17{word_q[14]}}, word_q[14:0]};
        end else begin : g_imm_zext
            assign bus.imm = {17'b0, word_q[14:0]};
        end
    endgenerate

    // A held skid entry must always be backed by back-pressure, or fetch would overrun it.
    a_skid_implies_stall: assert property (@(posedge clk) disable iff (!rst_n)
        skid_valid_q |-> stall_q);

    // Fetch withholds the halt opcode and raises done_in instead.
    a_no_halt_op_accepted: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> (bus.instr_in[31:27] != HALT_OP));

endmodule
